issue_queue: RTL and testbench

- Out-of-order issue queue directly downstream of register renaming; accepts renamed instructions (physical source/dest tags plus an opaque decoded payload) one per cycle.
- Tracks per-source readiness through writeback wakeup broadcasts and issues the oldest ready entry to the ALU/memory path each cycle.
- Supports branch-mispredict squash by instruction tag and full flush from the hazard controller.

---
 rtl/issue_queue_if.sv | 56 +++++
 rtl/issue_queue.sv | 142 ++++++++++++++
 tb/tb_issue_queue.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/issue_queue_if.sv
// Issue queue bus: rename-side enqueue, writeback wakeup, execute-side issue,
// and recovery controls. Rename/execute drive through master; the queue uses slave.
interface issue_queue_if #(
  parameter int DEPTH     = 16,
  parameter int PREG_W    = 6,
  parameter int TAG_W     = 32,
  parameter int PAYLOAD_W = 96
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 enq_valid;
  logic                 enq_ready;
  logic [TAG_W-1:0]     enq_tag;
  logic                 enq_uses_rs;
  logic                 enq_uses_rt;
  logic                 enq_uses_rw;
  logic [PREG_W-1:0]    enq_rs_phys;
  logic [PREG_W-1:0]    enq_rt_phys;
  logic [PREG_W-1:0]    enq_rw_phys;
  logic                 enq_rs_rdy;
  logic                 enq_rt_rdy;
  logic [PAYLOAD_W-1:0] enq_payload;

  logic                 wb_valid;
  logic [PREG_W-1:0]    wb_phys;

  logic                 iss_valid;
  logic                 iss_ready;
  logic [TAG_W-1:0]     iss_tag;
  logic [PREG_W-1:0]    iss_rs_phys;
  logic [PREG_W-1:0]    iss_rt_phys;
  logic [PREG_W-1:0]    iss_rw_phys;
  logic                 iss_uses_rw;
  logic [PAYLOAD_W-1:0] iss_payload;

  logic                 squash_valid;
  logic [TAG_W-1:0]     squash_tag;
  logic                 flush;
  logic [CNT_W-1:0]     count;

  modport master (
    output enq_valid, enq_tag, enq_uses_rs, enq_uses_rt, enq_uses_rw,
           enq_rs_phys, enq_rt_phys, enq_rw_phys, enq_rs_rdy, enq_rt_rdy, enq_payload,
           wb_valid, wb_phys, iss_ready, squash_valid, squash_tag, flush,
    input  enq_ready, iss_valid, iss_tag, iss_rs_phys, iss_rt_phys, iss_rw_phys,
           iss_uses_rw, iss_payload, count
  );

  modport slave (
    input  enq_valid, enq_tag, enq_uses_rs, enq_uses_rt, enq_uses_rw,
           enq_rs_phys, enq_rt_phys, enq_rw_phys, enq_rs_rdy, enq_rt_rdy, enq_payload,
           wb_valid, wb_phys, iss_ready, squash_valid, squash_tag, flush,
    output enq_ready, iss_valid, iss_tag, iss_rs_phys, iss_rt_phys, iss_rw_phys,
           iss_uses_rw, iss_payload, count
  );
endinterface

// File: rtl/issue_queue.sv
// Out-of-order issue queue: holds renamed instructions until both sources are
// woken, then issues the oldest ready one (wrap-aware tag age). Supports squash/flush.
module issue_queue #(
  parameter int DEPTH     = 16,
  parameter int PREG_W    = 6,
  parameter int TAG_W     = 32,
  parameter int PAYLOAD_W = 96
) (
  input  logic         clk,
  input  logic         rst,
  issue_queue_if.slave io
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                 valid;
    logic [TAG_W-1:0]     tag;
    logic                 uses_rs;
    logic                 uses_rt;
    logic                 uses_rw;
    logic [PREG_W-1:0]    rs_phys;
    logic [PREG_W-1:0]    rt_phys;
    logic [PREG_W-1:0]    rw_phys;
    logic                 rs_rdy;
    logic                 rt_rdy;
    logic [PAYLOAD_W-1:0] payload;
  } slot_t;

  slot_t            slots_q [DEPTH];
  logic [CNT_W-1:0] count_q;

  // a is older than b when (a - b) is negative in TAG_W-bit two's complement.
  function automatic logic is_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return d[TAG_W-1];
  endfunction

  function automatic logic is_younger(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] d;
    d = a - b;
    return !d[TAG_W-1] && (d != '0);
  endfunction

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [TAG_W-1:0] win_tag;
  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic [CNT_W-1:0] kill_cnt;
  logic             iss_valid;
  logic             iss_fire;
  logic             enq_ready;
  logic             enq_fire;
  slot_t            new_slot;

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves one unassigned would infer a latch.
  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    win_tag    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    kill_cnt   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (slots_q[i].valid && slots_q[i].rs_rdy && slots_q[i].rt_rdy &&
          (!win_found || is_older(slots_q[i].tag, win_tag))) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_tag   = slots_q[i].tag;
      end
      if (!slots_q[i].valid && !free_found) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (io.squash_valid && slots_q[i].valid && is_younger(slots_q[i].tag, io.squash_tag))
        kill_cnt = kill_cnt + 1'b1;
    end
  end

  // A squashed winner blocks issue for the cycle; no younger-priority fallback.
  assign iss_valid = win_found && !io.flush &&
                     !(io.squash_valid && is_younger(win_tag, io.squash_tag));
  assign iss_fire  = iss_valid && io.iss_ready;
  assign enq_ready = (count_q != CNT_W'(DEPTH));
  assign enq_fire  = io.enq_valid && enq_ready && free_found && !io.flush &&
                     !(io.squash_valid && is_younger(io.enq_tag, io.squash_tag));

  // Sources matching this cycle's writeback are captured ready (bypass).
  always_comb begin
    new_slot         = '0;
    new_slot.valid   = 1'b1;
    new_slot.tag     = io.enq_tag;
    new_slot.uses_rs = io.enq_uses_rs;
    new_slot.uses_rt = io.enq_uses_rt;
    new_slot.uses_rw = io.enq_uses_rw;
    new_slot.rs_phys = io.enq_rs_phys;
    new_slot.rt_phys = io.enq_rt_phys;
    new_slot.rw_phys = io.enq_rw_phys;
    new_slot.payload = io.enq_payload;
    new_slot.rs_rdy  = !io.enq_uses_rs || io.enq_rs_rdy ||
                       (io.wb_valid && io.wb_phys == io.enq_rs_phys);
    new_slot.rt_rdy  = !io.enq_uses_rt || io.enq_rt_rdy ||
                       (io.wb_valid && io.wb_phys == io.enq_rt_phys);
  end

  // NOTE: only the valid bits are reset; slot contents are don't-care until
  // written by an enqueue, so the storage needs no reset network.
  always_ff @(posedge clk) begin
    if (rst || io.flush) begin
      for (int i = 0; i < DEPTH; i++) slots_q[i].valid <= 1'b0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (slots_q[i].valid) begin
          if (io.wb_valid && slots_q[i].uses_rs && slots_q[i].rs_phys == io.wb_phys)
            slots_q[i].rs_rdy <= 1'b1;
          if (io.wb_valid && slots_q[i].uses_rt && slots_q[i].rt_phys == io.wb_phys)
            slots_q[i].rt_rdy <= 1'b1;
          if (io.squash_valid && is_younger(slots_q[i].tag, io.squash_tag))
            slots_q[i].valid <= 1'b0;
        end
      end
      if (iss_fire) slots_q[win_idx].valid <= 1'b0;
      if (enq_fire) slots_q[free_idx] <= new_slot;
      // The issued winner is never a squash victim, so it is not double-counted.
      count_q <= count_q + CNT_W'(enq_fire) - CNT_W'(iss_fire) - kill_cnt;
    end
  end

  assign io.enq_ready   = enq_ready;
  assign io.count       = count_q;
  assign io.iss_valid   = iss_valid;
  assign io.iss_tag     = iss_valid ? slots_q[win_idx].tag     : '0;
  assign io.iss_rs_phys = iss_valid ? slots_q[win_idx].rs_phys : '0;
  assign io.iss_rt_phys = iss_valid ? slots_q[win_idx].rt_phys : '0;
  assign io.iss_rw_phys = iss_valid ? slots_q[win_idx].rw_phys : '0;
  assign io.iss_uses_rw = iss_valid ? slots_q[win_idx].uses_rw : 1'b0;
  assign io.iss_payload = iss_valid ? slots_q[win_idx].payload : '0;
endmodule

// File: tb/tb_issue_queue.sv
// Directed bench for issue_queue: ordering, wakeup/bypass, full/empty,
// squash, flush, reset and tag wrap-around age.
module tb_issue_queue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  issue_queue_if #(.DEPTH(16), .PREG_W(6), .TAG_W(32), .PAYLOAD_W(96)) bus ();

  issue_queue #(.DEPTH(16), .PREG_W(6), .TAG_W(32), .PAYLOAD_W(96)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.enq_valid    = 1'b0;
    bus.enq_tag      = '0;
    bus.enq_uses_rs  = 1'b0;
    bus.enq_uses_rt  = 1'b0;
    bus.enq_uses_rw  = 1'b0;
    bus.enq_rs_phys  = '0;
    bus.enq_rt_phys  = '0;
    bus.enq_rw_phys  = '0;
    bus.enq_rs_rdy   = 1'b0;
    bus.enq_rt_rdy   = 1'b0;
    bus.enq_payload  = '0;
    bus.wb_valid     = 1'b0;
    bus.wb_phys      = '0;
    bus.iss_ready    = 1'b0;
    bus.squash_valid = 1'b0;
    bus.squash_tag   = '0;
    bus.flush        = 1'b0;
  endtask

  task automatic drive_enq(input logic [31:0] tag, input logic urs, input logic [5:0] rs,
                           input logic rs_rdy, input logic urt, input logic [5:0] rt,
                           input logic rt_rdy);
    bus.enq_valid   = 1'b1;
    bus.enq_tag     = tag;
    bus.enq_uses_rs = urs;
    bus.enq_rs_phys = rs;
    bus.enq_rs_rdy  = rs_rdy;
    bus.enq_uses_rt = urt;
    bus.enq_rt_phys = rt;
    bus.enq_rt_rdy  = rt_rdy;
    bus.enq_uses_rw = 1'b1;
    bus.enq_rw_phys = tag[5:0];
    bus.enq_payload = {tag, ~tag, tag};
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL reset_enq_ready got %b want 1", bus.enq_ready); end
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %b want 0", bus.iss_valid); end
    checks++; if (bus.iss_tag !== 32'd0 || bus.iss_payload !== 96'd0) begin errors++; $display("FAIL reset_iss_fields got tag %0h want 0", bus.iss_tag); end
  endtask

  task automatic test_wakeup_order();
    drive_enq(32'd5, 1'b1, 6'd33, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL order_busy_not_issued got %b want 0", bus.iss_valid); end
    drive_enq(32'd6, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    bus.enq_valid = 1'b0;
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_tag !== 32'd6) begin errors++; $display("FAIL order_ready_first got v=%b tag=%0d want v=1 tag=6", bus.iss_valid, bus.iss_tag); end
    checks++; if (bus.iss_payload !== {32'd6, ~32'd6, 32'd6} || bus.iss_rw_phys !== 6'd6 || bus.iss_uses_rw !== 1'b1) begin errors++; $display("FAIL order_payload got %h want %h", bus.iss_payload, {32'd6, ~32'd6, 32'd6}); end
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL order_count2 got %0d want 2", bus.count); end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd1 || bus.iss_valid !== 1'b0) begin errors++; $display("FAIL order_after_issue got cnt=%0d v=%b want cnt=1 v=0", bus.count, bus.iss_valid); end
    bus.wb_valid = 1'b1;
    bus.wb_phys  = 6'd33;
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_tag !== 32'd5 || bus.iss_rs_phys !== 6'd33) begin errors++; $display("FAIL order_woken got v=%b tag=%0d want v=1 tag=5", bus.iss_valid, bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL order_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 16; i++) begin
      drive_enq(32'd100 + 32'(i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      tick();
    end
    checks++; if (bus.count !== 5'd16 || bus.enq_ready !== 1'b0) begin errors++; $display("FAIL full_state got cnt=%0d rdy=%b want cnt=16 rdy=0", bus.count, bus.enq_ready); end
    drive_enq(32'd50, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    checks++; if (bus.count !== 5'd16 || bus.iss_tag !== 32'd100) begin errors++; $display("FAIL full_enq_ignored got cnt=%0d tag=%0d want cnt=16 tag=100", bus.count, bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    bus.enq_valid = 1'b0;
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd15 || bus.iss_tag !== 32'd101) begin errors++; $display("FAIL full_issue_no_same_cycle_enq got cnt=%0d tag=%0d want cnt=15 tag=101", bus.count, bus.iss_tag); end
    checks++; if (bus.enq_ready !== 1'b1) begin errors++; $display("FAIL full_ready_again got %b want 1", bus.enq_ready); end
    bus.iss_ready = 1'b1;
    repeat (15) tick();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0 || bus.iss_valid !== 1'b0) begin errors++; $display("FAIL full_drained got cnt=%0d v=%b want cnt=0 v=0", bus.count, bus.iss_valid); end
  endtask

  task automatic test_bypass();
    drive_enq(32'd9, 1'b1, 6'd40, 1'b0, 1'b0, 6'd0, 1'b0);
    bus.wb_valid = 1'b1;
    bus.wb_phys  = 6'd40;
    tick();
    clear_inputs();
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_tag !== 32'd9) begin errors++; $display("FAIL bypass_issuable got v=%b tag=%0d want v=1 tag=9", bus.iss_valid, bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
    drive_enq(32'd20, 1'b0, 6'd0, 1'b0, 1'b1, 6'd41, 1'b0);
    bus.wb_phys = 6'd41;
    tick();
    bus.enq_valid = 1'b0;
    checks++; if (bus.iss_valid !== 1'b0 || bus.count !== 5'd1) begin errors++; $display("FAIL bypass_needs_wb_valid got v=%b cnt=%0d want v=0 cnt=1", bus.iss_valid, bus.count); end
    bus.wb_valid = 1'b1;
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.iss_valid !== 1'b1 || bus.iss_tag !== 32'd20 || bus.iss_rt_phys !== 6'd41) begin errors++; $display("FAIL bypass_rt_wakeup got v=%b tag=%0d want v=1 tag=20", bus.iss_valid, bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
  endtask

  task automatic test_squash();
    for (int i = 0; i < 4; i++) begin
      drive_enq(32'd10 + 32'(i), 1'b1, 6'(50 + i), 1'b0, 1'b0, 6'd0, 1'b0);
      tick();
    end
    bus.enq_valid = 1'b0;
    checks++; if (bus.count !== 5'd4) begin errors++; $display("FAIL squash_pre_count got %0d want 4", bus.count); end
    bus.squash_valid = 1'b1;
    bus.squash_tag   = 32'd11;
    tick();
    bus.squash_valid = 1'b0;
    checks++; if (bus.count !== 5'd2) begin errors++; $display("FAIL squash_count got %0d want 2", bus.count); end
    bus.wb_valid = 1'b1;
    bus.wb_phys  = 6'd52;
    tick();
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL squash_killed_stays_dead got %b want 0", bus.iss_valid); end
    bus.wb_phys = 6'd51;
    tick();
    checks++; if (bus.iss_tag !== 32'd11 || bus.iss_valid !== 1'b1) begin errors++; $display("FAIL squash_branch_kept got tag=%0d want 11", bus.iss_tag); end
    bus.wb_phys = 6'd50;
    tick();
    bus.wb_valid = 1'b0;
    checks++; if (bus.iss_tag !== 32'd10) begin errors++; $display("FAIL squash_oldest_first got %0d want 10", bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    checks++; if (bus.iss_tag !== 32'd11) begin errors++; $display("FAIL squash_second_issue got %0d want 11", bus.iss_tag); end
    tick();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL squash_drained got %0d want 0", bus.count); end
    drive_enq(32'd30, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    drive_enq(32'd31, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    bus.squash_valid = 1'b1;
    bus.squash_tag   = 32'd29;
    bus.iss_ready    = 1'b1;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL squash_masks_issue got %b want 0", bus.iss_valid); end
    tick();
    drive_enq(32'd28, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL squash_drops_young_enq got %0d want 0", bus.count); end
    tick();
    clear_inputs();
    checks++; if (bus.count !== 5'd1 || bus.iss_tag !== 32'd28) begin errors++; $display("FAIL squash_keeps_old_enq got cnt=%0d tag=%0d want cnt=1 tag=28", bus.count, bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    bus.iss_ready = 1'b0;
  endtask

  task automatic test_wrap();
    drive_enq(32'h0000_0001, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    drive_enq(32'hFFFF_FFFE, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    tick();
    bus.enq_valid = 1'b0;
    checks++; if (bus.iss_tag !== 32'hFFFF_FFFE) begin errors++; $display("FAIL wrap_oldest got %h want fffffffe", bus.iss_tag); end
    bus.iss_ready = 1'b1;
    tick();
    checks++; if (bus.iss_tag !== 32'h0000_0001) begin errors++; $display("FAIL wrap_second got %h want 00000001", bus.iss_tag); end
    tick();
    bus.iss_ready = 1'b0;
    checks++; if (bus.count !== 5'd0) begin errors++; $display("FAIL wrap_drained got %0d want 0", bus.count); end
  endtask

  task automatic test_flush_and_reset();
    for (int i = 0; i < 3; i++) begin
      drive_enq(32'd60 + 32'(i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      tick();
    end
    checks++; if (bus.count !== 5'd3) begin errors++; $display("FAIL flush_pre_count got %0d want 3", bus.count); end
    drive_enq(32'd77, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    bus.flush     = 1'b1;
    bus.iss_ready = 1'b1;
    #1;
    checks++; if (bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_masks_issue got %b want 0", bus.iss_valid); end
    tick();
    clear_inputs();
    checks++; if (bus.count !== 5'd0 || bus.iss_valid !== 1'b0) begin errors++; $display("FAIL flush_clears got cnt=%0d v=%b want cnt=0 v=0", bus.count, bus.iss_valid); end
    for (int i = 0; i < 2; i++) begin
      drive_enq(32'd70 + 32'(i), 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
      tick();
    end
    drive_enq(32'd72, 1'b0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    checks++; if (bus.count !== 5'd0 || bus.enq_ready !== 1'b1 || bus.iss_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_fill got cnt=%0d rdy=%b v=%b want 0 1 0", bus.count, bus.enq_ready, bus.iss_valid); end
  endtask

  initial begin
    test_reset();
    test_wakeup_order();
    test_full();
    test_bypass();
    test_squash();
    test_wrap();
    test_flush_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
